// File: rtl/imem_fetch_sequencer_if.sv
// Fetch-side bundle: pipeline IF handshake, branch redirect and the narrow
// instruction-memory read port.
`timescale 1ns/1ps

interface imem_fetch_sequencer_if #(
    parameter int unsigned MEM_WIDTH = 16
);
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 ir_ready;
    logic                 ir_valid;
    logic [31:0]          ir;
    logic [31:0]          ir_pc;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic [MEM_WIDTH-1:0] mem_rdata;

    // Sequencer side
    modport master (
        input  redirect, redirect_pc, ir_ready, mem_rdata,
        output ir_valid, ir, ir_pc, mem_req, mem_addr
    );

    // Pipeline/memory side
    modport slave (
        output redirect, redirect_pc, ir_ready, mem_rdata,
        input  ir_valid, ir, ir_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction-fetch sequencer: reads one 32-bit instruction as BEATS narrow beats,
// assembles them little-endian and hands the result to IF over valid/ready.
`timescale 1ns/1ps

module imem_fetch_sequencer #(
    parameter int unsigned MEM_WIDTH   = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    imem_fetch_sequencer_if.master bus
);
    localparam int unsigned BEATS      = 32 / MEM_WIDTH;
    localparam int unsigned BEAT_BYTES = MEM_WIDTH / 8;
    localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]       ret_cnt_q, ret_cnt_d;
    logic [MEM_LATENCY-1:0] inflight_q, inflight_d;
    logic [31:0]            ir_q, ir_d;
    logic [31:0]            ir_pc_q, ir_pc_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   mem_req_c;
    logic                   beat_ret_c;
    logic [31:0]            redirect_pc_c;

    assign redirect_pc_c = bus.redirect_pc & ~32'd3;
    assign beat_ret_c    = inflight_q[MEM_LATENCY-1];

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            beat_cnt_q <= '0;
            ret_cnt_q  <= '0;
            inflight_q <= '0;
            ir_q       <= '0;
            ir_pc_q    <= RESET_PC;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            beat_cnt_q <= beat_cnt_d;
            ret_cnt_q  <= ret_cnt_d;
            inflight_q <= inflight_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Next-state, beat issue/collect and redirect handling
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        beat_cnt_d = beat_cnt_q;
        ret_cnt_d  = ret_cnt_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        mem_req_c  = (state_q == FETCH) && !bus.redirect;
        inflight_d = MEM_LATENCY'({inflight_q, mem_req_c});

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (beat_cnt_q == LAST_BEAT) begin
                    beat_cnt_d = '0;
                    state_d    = WAIT;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            WAIT: ;
            HOLD: begin
                if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (inflight_d == '0) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Returning beats may arrive while later beats are still being issued
        if ((state_q == FETCH || state_q == WAIT) && beat_ret_c) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (ret_cnt_q == CNT_W'(k)) ir_d[k*MEM_WIDTH +: MEM_WIDTH] = bus.mem_rdata;
            end
            if (ret_cnt_q == LAST_BEAT) begin
                ret_cnt_d  = '0;
                ir_valid_d = 1'b1;
                ir_pc_d    = pc_q;
                state_d    = HOLD;
            end else begin
                ret_cnt_d = ret_cnt_q + CNT_W'(1);
            end
        end

        // Redirect overrides everything above; a beat landing this cycle is stale
        if (bus.redirect) begin
            pc_d = redirect_pc_c;
            if (state_q != IDLE) begin
                beat_cnt_d = '0;
                ret_cnt_d  = '0;
                ir_valid_d = 1'b0;
                ir_d       = ir_q;
                state_d    = (inflight_d != '0) ? DRAIN : FETCH;
            end
        end
    end

    // mem_req/mem_addr are combinational so redirect can suppress a beat in its own cycle
    assign bus.mem_req  = mem_req_c;
    assign bus.mem_addr = pc_q + 32'(beat_cnt_q) * 32'(BEAT_BYTES);
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;

endmodule
